// File: rtl/register_file_mp.sv
// register_file_mp
//   Parametrised multi-read-port register file for the 64-bit datapath, placed
//   between decode (read addresses) and writeback (write port). Reads are
//   synchronous with one cycle of latency. A same-cycle write is bypassed to any
//   read of the same address. Entry 0 can be hardwired to zero. After reset, a
//   sweep clears one entry per cycle, and the ports are ignored until the sweep
//   completes.
//
// Ports
//   clk       in   1              rising-edge clock
//   rst       in   1              synchronous, active-high reset
//   ready     out  1              1 = clear sweep finished, ports accepted
//   wr_en     in   1              write strobe
//   wr_addr   in   ADDR_W         write address
//   wr_data   in   DATA_W         write data
//   rd_en     in   NUM_RD         per-port read strobe
//   rd_addr   in   NUM_RD*ADDR_W  port p address = rd_addr[p*ADDR_W +: ADDR_W]
//   rd_data   out  NUM_RD*DATA_W  port p data    = rd_data[p*DATA_W +: DATA_W]
//   rd_valid  out  NUM_RD         per-port: rd_data updated this cycle
module register_file_mp #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     ready,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_valid
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {CLEAR, READY} stateType;

   stateType          state;
   stateType          stateNext;
   logic [ADDR_W-1:0] clrIdx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              writeHit;

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else     state <= stateNext;
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      stateNext = state;
      if (state == CLEAR && clrIdx == '1) stateNext = READY;
   end

   assign ready = (state == READY);

   // The sweep index only advances while clearing; reset restarts it at 0.
   always_ff @(posedge clk) begin
      if (rst)                 clrIdx <= '0;
      else if (state == CLEAR) clrIdx <= clrIdx + 1'b1;
   end

   // ---------------------------------------------------------------- storage
   // Writes to entry 0 are dropped when it is hardwired to zero.
   assign writeHit = (state == READY) && wr_en &&
                     !((ZERO_REG != 0) && (wr_addr == '0));

   // NOTE: the array has no reset branch. It is zeroed by the clear sweep,
   // which keeps it mappable to RAM/latch-array macros.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) mem[clrIdx]  <= '0;
         else if (writeHit)  mem[wr_addr] <= wr_data;
      end
   end

   // ---------------------------------------------------------------- read ports
   logic [DATA_W-1:0] rdDataQ  [NUM_RD];
   logic              rdValidQ [NUM_RD];

   for (genvar p = 0; p < NUM_RD; p++) begin : gRead
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr[p*ADDR_W +: ADDR_W];

      always_ff @(posedge clk) begin
         if (rst) begin
            rdDataQ[p]  <= '0;
            rdValidQ[p] <= 1'b0;
         end else if (state == READY && rd_en[p]) begin
            // Priority: hardwired zero, then same-cycle write bypass, then array.
            if ((ZERO_REG != 0) && addr == '0)  rdDataQ[p] <= '0;
            else if (wr_en && wr_addr == addr)  rdDataQ[p] <= wr_data;
            else                                rdDataQ[p] <= mem[addr];
            rdValidQ[p] <= 1'b1;
         end else begin
            rdValidQ[p] <= 1'b0;   // data holds its previous value
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = rdDataQ[p];
      assign rd_valid[p]                 = rdValidQ[p];
   end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
//   Self-checking bench for register_file_mp configured with 4 read ports and a
//   hardwired-zero entry 0. A behavioural model (a plain array, a ready flag and
//   a clear-cycle counter) predicts every output after every edge. Directed
//   scenarios come first, followed by a randomized phase.
module tb_register_file_mp;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NR = 4;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             ready;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic [NR-1:0]    rd_en;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_valid;

   register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
   endtask

   // ---------------------------------------------------------------- model
   logic [DW-1:0] mdlMem [DEPTH];
   bit            mdlReady = 0;
   int            mdlClr   = 0;
   logic [DW-1:0] expData  [NR];
   logic          expValid [NR];

   initial for (int p = 0; p < NR; p++) begin expData[p] = '0; expValid[p] = 1'b0; end

   // Predict the effect of the coming edge from the current inputs, take the
   // edge, then compare every output.
   task automatic step();
      logic [DW-1:0] nd [NR];
      logic          nv [NR];
      logic [AW-1:0] a;
      for (int p = 0; p < NR; p++) begin nd[p] = expData[p]; nv[p] = 1'b0; end
      if (rst) begin
         mdlReady = 0;
         mdlClr   = 0;
         for (int p = 0; p < NR; p++) nd[p] = '0;
      end else if (!mdlReady) begin
         mdlMem[mdlClr] = '0;
         mdlClr++;
         if (mdlClr == DEPTH) mdlReady = 1;
      end else begin
         for (int p = 0; p < NR; p++) if (rd_en[p]) begin
            a = rd_addr[p*AW +: AW];
            if (a == 0)                        nd[p] = '0;
            else if (wr_en && wr_addr == a)    nd[p] = wr_data;
            else                               nd[p] = mdlMem[a];
            nv[p] = 1'b1;
         end
         if (wr_en && wr_addr != 0) mdlMem[wr_addr] = wr_data;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NR; p++) begin expData[p] = nd[p]; expValid[p] = nv[p]; end
      check("ready", {63'd0, ready}, {63'd0, mdlReady});
      for (int p = 0; p < NR; p++) begin
         check($sformatf("rd_valid%0d", p), {63'd0, rd_valid[p]}, {63'd0, nv[p]});
         check($sformatf("rd_data%0d", p), rd_data[p*DW +: DW], nd[p]);
      end
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
   endtask

   task automatic setRead(input int p, input logic [AW-1:0] a);
      rd_en[p] = 1'b1;
      rd_addr[p*AW +: AW] = a;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1;
      idle();

      // 1. Reset, sweep length, then every entry reads zero.
      step();
      rst = 1'b0;
      for (int e = 1; e <= DEPTH; e++) begin
         step();
         if (e == DEPTH - 1) check("ready_low_at_31", {63'd0, ready}, 64'd0);
      end
      check("ready_high_at_32", {63'd0, ready}, 64'd1);
      for (int a = 0; a < DEPTH; a++) begin
         idle();
         setRead(0, AW'(a));
         setRead(3, AW'(DEPTH - 1 - a));
         step();
      end

      // 2. Write then read r5.
      idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0123_4567; step();
      idle(); setRead(0, 5'd5); step();
      check("t2_data", rd_data[0 +: DW], 64'hDEAD_BEEF_0123_4567);
      check("t2_valid", {63'd0, rd_valid[0]}, 64'd1);

      // 3. Same-cycle bypass on port 1.
      idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1; step();
      idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = {8{8'hA5}}; setRead(1, 5'd7); step();
      check("t3_bypass", rd_data[DW +: DW], 64'hA5A5_A5A5_A5A5_A5A5);

      // 4. Hardwired zero on entry 0.
      idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = '1; step();
      idle(); setRead(0, 5'd0); setRead(1, 5'd0); step();
      check("t4_zero0", rd_data[0 +: DW], 64'd0);
      check("t4_zero1", rd_data[DW +: DW], 64'd0);
      check("t4_valid", {62'd0, rd_valid[1:0]}, 64'd3);

      // 5. Reset mid-sweep; writes during clear are lost.
      idle(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h1234; step();
      rst = 1'b1; idle(); step();
      rst = 1'b0;
      for (int e = 0; e < 10; e++) step();
      rst = 1'b1; step();
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hBAD0_BAD0;
      setRead(0, 5'd9);
      for (int e = 1; e <= DEPTH; e++) step();
      check("t5_ready_after_restart", {63'd0, ready}, 64'd1);
      idle(); setRead(2, 5'd9); step();
      check("t5_lost_write", rd_data[2*DW +: DW], 64'd0);

      // 6. Four ports, shared address, then drop rd_en.
      idle(); wr_en = 1'b1; wr_addr = 5'd1;  wr_data = 64'h1111_0000_0000_0001; step();
      idle(); wr_en = 1'b1; wr_addr = 5'd2;  wr_data = 64'h2222_0000_0000_0002; step();
      idle(); wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h3131_0000_0000_001F; step();
      idle(); setRead(0, 5'd1); setRead(1, 5'd2); setRead(2, 5'd1); setRead(3, 5'd31); step();
      check("t6_p0", rd_data[0*DW +: DW], 64'h1111_0000_0000_0001);
      check("t6_p1", rd_data[1*DW +: DW], 64'h2222_0000_0000_0002);
      check("t6_p2", rd_data[2*DW +: DW], 64'h1111_0000_0000_0001);
      check("t6_p3", rd_data[3*DW +: DW], 64'h3131_0000_0000_001F);
      idle(); step();
      check("t6_valid_drop", {60'd0, rd_valid}, 64'd0);
      check("t6_hold_p3", rd_data[3*DW +: DW], 64'h3131_0000_0000_001F);

      // 7. Randomized traffic with occasional reset.
      for (int c = 0; c < 600; c++) begin
         rst     = ($urandom_range(0, 249) == 0);
         wr_en   = 1'($urandom);
         wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         wr_data = {$urandom, $urandom};
         rd_en   = NR'($urandom);
         for (int p = 0; p < NR; p++)
            rd_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         step();
      end

      rst = 1'b0;
      idle();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
